// File: rtl/pinball_pkg.sv
// Shared types and widths for the pinball game-state logic.
package pinball_pkg;

   localparam int LIFE_W    = 4;
   localparam int SCORE_W   = 4;
   localparam int SCORE_MAX = 15;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PLAY,
      ST_RESPAWN,
      ST_GAME_OVER,
      ST_WIN
   } game_state_t;

   // 5-bit sum clamped to SCORE_MAX so a big target never wraps the score
   function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                  input logic [SCORE_W-1:0] b);
      logic [SCORE_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return (s > (SCORE_W+1)'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX) : s[SCORE_W-1:0];
   endfunction

endpackage

// File: rtl/frame_event_latch.sv
// Per-frame event capture: first hit (with its value) and any ball loss.
// Held clear whenever enable is low, so nothing stale survives a state change.
module frame_event_latch
   import pinball_pkg::*;
(
   input  logic               clk,
   input  logic               resetN,
   input  logic               enable,
   input  logic               startOfFrame,
   input  logic               hitValid,
   input  logic [SCORE_W-1:0] hitValue,
   input  logic               ballLost,
   output logic               hitPend,
   output logic [SCORE_W-1:0] hitVal,
   output logic               lossPend
);

   // Clear on frame start, but the frame-start cycle itself belongs to the new frame
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         hitPend  <= 1'b0;
         hitVal   <= '0;
         lossPend <= 1'b0;
      end else if (!enable) begin
         hitPend  <= 1'b0;
         hitVal   <= '0;
         lossPend <= 1'b0;
      end else if (startOfFrame) begin
         hitPend  <= hitValid;
         hitVal   <= hitValid ? hitValue : '0;
         lossPend <= ballLost;
      end else begin
         if (hitValid && !hitPend) begin
            hitPend <= 1'b1;
            hitVal  <= hitValue;
         end
         if (ballLost)
            lossPend <= 1'b1;
      end
   end

endmodule

// File: rtl/game_status_block.sv
// Game lifecycle FSM: turns per-frame hit/loss events into score, lives and
// play/respawn/game-over/win state. All outputs come from registers.
module game_status_block
   import pinball_pkg::*;
#(
   parameter int INIT_LIFE      = 3,
   parameter int WIN_SCORE      = 15,
   parameter int RESPAWN_FRAMES = 60
)(
   input  logic               clk,
   input  logic               resetN,
   input  logic               startOfFrame,
   input  logic               startGame,
   input  logic               hitValid,
   input  logic [SCORE_W-1:0] hitValue,
   input  logic               ballLost,
   output logic [LIFE_W-1:0]  life,
   output logic [SCORE_W-1:0] score,
   output logic [SCORE_W-1:0] scoreNumber,
   output logic               freezeBall,
   output logic               gameOver,
   output logic               gameWon
);

   game_state_t        state, state_n;
   logic [LIFE_W-1:0]  life_n;
   logic [SCORE_W-1:0] score_n, num_n, sum;
   logic [7:0]         cnt, cnt_n;
   logic               hitPend, lossPend;
   logic [SCORE_W-1:0] hitVal;

   frame_event_latch u_latch (
      .clk          (clk),
      .resetN       (resetN),
      .enable       (state == ST_PLAY),
      .startOfFrame (startOfFrame),
      .hitValid     (hitValid),
      .hitValue     (hitValue),
      .ballLost     (ballLost),
      .hitPend      (hitPend),
      .hitVal       (hitVal),
      .lossPend     (lossPend)
   );

   assign sum = sat_add(score, hitVal);

   // Next-state and datapath updates; commits happen only on frame start
   always_comb begin
      state_n = state;
      life_n  = life;
      score_n = score;
      num_n   = scoreNumber;
      cnt_n   = cnt;
      case (state)
         ST_IDLE, ST_GAME_OVER, ST_WIN: begin
            if (startGame) begin
               state_n = ST_PLAY;
               life_n  = LIFE_W'(INIT_LIFE);
               score_n = '0;
               num_n   = '0;
               cnt_n   = '0;
            end
         end
         ST_PLAY: begin
            if (startOfFrame) begin
               if (hitPend) begin
                  score_n = sum;
                  num_n   = hitVal;
               end
               // a win in the same frame as a loss keeps the life
               if (hitPend && (sum >= SCORE_W'(WIN_SCORE))) begin
                  state_n = ST_WIN;
               end else if (lossPend) begin
                  if (life == LIFE_W'(1)) begin
                     life_n  = '0;
                     state_n = ST_GAME_OVER;
                  end else begin
                     life_n  = life - LIFE_W'(1);
                     cnt_n   = 8'(RESPAWN_FRAMES);
                     state_n = ST_RESPAWN;
                  end
               end
            end
         end
         ST_RESPAWN: begin
            if (startOfFrame) begin
               if (cnt <= 8'd1) begin
                  cnt_n   = '0;
                  state_n = ST_PLAY;
               end else begin
                  cnt_n = cnt - 8'd1;
               end
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // State and game registers
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state       <= ST_IDLE;
         life        <= LIFE_W'(INIT_LIFE);
         score       <= '0;
         scoreNumber <= '0;
         cnt         <= '0;
      end else begin
         state       <= state_n;
         life        <= life_n;
         score       <= score_n;
         scoreNumber <= num_n;
         cnt         <= cnt_n;
      end
   end

   assign freezeBall = (state != ST_PLAY);
   assign gameOver   = (state == ST_GAME_OVER);
   assign gameWon    = (state == ST_WIN);

endmodule

// File: tb/tb_game_status_block.sv
// Directed bench: stimulus pushes hand-computed expectations tagged with the
// cycle they must appear on; a monitor pops and compares on the falling edge.
module tb_game_status_block;

   logic       clk = 1'b0;
   logic       resetN = 1'b0;
   logic       startOfFrame = 1'b0;
   logic       startGame = 1'b0;
   logic       hitValid = 1'b0;
   logic [3:0] hitValue = 4'd0;
   logic       ballLost = 1'b0;
   logic [3:0] life, score, scoreNumber;
   logic       freezeBall, gameOver, gameWon;

   game_status_block #(.INIT_LIFE(3), .WIN_SCORE(15), .RESPAWN_FRAMES(60)) dut (
      .clk          (clk),
      .resetN       (resetN),
      .startOfFrame (startOfFrame),
      .startGame    (startGame),
      .hitValid     (hitValid),
      .hitValue     (hitValue),
      .ballLost     (ballLost),
      .life         (life),
      .score        (score),
      .scoreNumber  (scoreNumber),
      .freezeBall   (freezeBall),
      .gameOver     (gameOver),
      .gameWon      (gameWon)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         at;
      logic [3:0] l, s, n;
      logic       f, o, w;
      string      name;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Monitor: compare every expectation due on this cycle
   always @(negedge clk) begin
      while (q.size() > 0 && q[0].at <= cyc) begin
         exp_t e;
         e = q.pop_front();
         n_cmp++;
         if (e.at != cyc ||
             {life, score, scoreNumber, freezeBall, gameOver, gameWon} !==
             {e.l, e.s, e.n, e.f, e.o, e.w}) begin
            n_bad++;
            $display("FAIL %s @%0d: got life=%0d score=%0d num=%0d frz=%0b over=%0b won=%0b, want life=%0d score=%0d num=%0d frz=%0b over=%0b won=%0b",
                     e.name, cyc, life, score, scoreNumber, freezeBall, gameOver, gameWon,
                     e.l, e.s, e.n, e.f, e.o, e.w);
         end
      end
   end

   task automatic expect_at(input int dly, input string nm, input int l, input int s,
                            input int n, input bit f, input bit o, input bit w);
      exp_t e;
      e.at = cyc + dly; e.l = 4'(l); e.s = 4'(s); e.n = 4'(n);
      e.f = f; e.o = o; e.w = w; e.name = nm;
      q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic cycles(input int n);
      repeat (n) tick();
   endtask

   task automatic sof_tick();
      startOfFrame = 1'b1; tick(); startOfFrame = 1'b0;
   endtask

   // One frame of activity, then commit with the expected post-commit state
   task automatic frame(input bit hit, input int val, input bit lost, input string nm,
                        input int l, input int s, input int n, input bit f, input bit o, input bit w);
      hitValid = hit; hitValue = 4'(val); ballLost = lost;
      cycles(3);
      hitValid = 1'b0; ballLost = 1'b0;
      cycles(1);
      expect_at(1, nm, l, s, n, f, o, w);
      sof_tick();
      cycles(2);
   endtask

   // 60 held frames; hits during the hold must not count
   task automatic respawn(input int l, input int s, input int n, input bit hit);
      for (int k = 1; k <= 60; k++) begin
         hitValid = hit; hitValue = 4'd5;
         cycles(3);
         hitValid = 1'b0;
         if (k < 60) expect_at(1, "respawn_hold", l, s, n, 1, 0, 0);
         else        expect_at(1, "respawn_exit", l, s, n, 0, 0, 0);
         sof_tick();
      end
      cycles(2);
   endtask

   initial begin
      cycles(3);
      expect_at(0, "reset", 3, 0, 0, 1, 0, 0);
      cycles(1);
      resetN = 1'b1;
      cycles(2);
      expect_at(1, "idle_sof", 3, 0, 0, 1, 0, 0);
      sof_tick();
      cycles(2);

      startGame = 1'b1;
      expect_at(1, "start", 3, 0, 0, 0, 0, 0);
      tick();
      startGame = 1'b0;
      cycles(2);
      expect_at(1, "empty_commit", 3, 0, 0, 0, 0, 0);
      sof_tick();

      // 200 cycles of the same hit in one frame score once
      hitValid = 1'b1; hitValue = 4'd4;
      cycles(200);
      hitValid = 1'b0;
      cycles(2);
      // hit sampled on the frame-start cycle belongs to the new frame
      expect_at(1, "multi_hit_once", 3, 4, 4, 0, 0, 0);
      hitValid = 1'b1; hitValue = 4'd2;
      sof_tick();
      hitValid = 1'b0;
      cycles(3);
      expect_at(1, "hit_on_sof", 3, 6, 2, 0, 0, 0);
      sof_tick();
      cycles(2);

      startGame = 1'b1;
      expect_at(1, "start_ignored_play", 3, 6, 2, 0, 0, 0);
      tick();
      startGame = 1'b0;
      cycles(2);

      frame(1, 0, 0, "zero_hit", 3, 6, 0, 0, 0, 0);
      frame(0, 0, 1, "loss_3", 2, 6, 0, 1, 0, 0);
      respawn(2, 6, 0, 1);
      frame(0, 0, 0, "no_leak", 2, 6, 0, 0, 0, 0);
      frame(0, 0, 1, "loss_2", 1, 6, 0, 1, 0, 0);
      respawn(1, 6, 0, 0);
      frame(0, 0, 1, "loss_last", 0, 6, 0, 1, 1, 0);
      frame(1, 7, 1, "over_hold", 0, 6, 0, 1, 1, 0);

      startGame = 1'b1;
      expect_at(1, "restart", 3, 0, 0, 0, 0, 0);
      tick();
      startGame = 1'b0;
      cycles(2);

      frame(1, 8, 0, "score8", 3, 8, 8, 0, 0, 0);
      frame(1, 5, 0, "score13", 3, 13, 5, 0, 0, 0);
      frame(1, 5, 1, "win_sat", 3, 15, 5, 1, 0, 1);
      frame(1, 3, 1, "win_hold", 3, 15, 5, 1, 0, 1);

      startGame = 1'b1;
      expect_at(1, "restart_win", 3, 0, 0, 0, 0, 0);
      tick();
      startGame = 1'b0;
      cycles(2);

      frame(1, 2, 1, "loss_then_reset", 2, 2, 2, 1, 0, 0);
      frame(0, 0, 0, "mid_respawn", 2, 2, 2, 1, 0, 0);
      resetN = 1'b0;
      expect_at(0, "reset_mid", 3, 0, 0, 1, 0, 0);
      cycles(2);
      resetN = 1'b1;
      frame(1, 9, 1, "post_reset_idle", 3, 0, 0, 1, 0, 0);

      cycles(3);
      n_cmp++;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d expectations left, want 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
